bldc_startup_sequencer: RTL
===========================

BLDC_STARTUP_SEQUENCER -- requirements
Module: bldc_startup_sequencer

Interface
REQ-001 SHALL have parameter ALIGN_CYCLES, default 1_000_000, rotor-alignment hold time in clk cycles (1..2^24-1).
REQ-002 SHALL have parameter ALIGN_GAIN, default 200, signed 10-bit gain applied during ALIGN and RAMP.
REQ-003 SHALL have parameter RAMP_STEP_CYCLES, default 5000, clk cycles per forced position step (1..2^24-1).
REQ-004 SHALL have parameter RAMP_STEPS, default 2340, forced position steps before closed loop (1..65535).
REQ-005 SHALL have parameter STALL_CYCLES, default 2_000_000, clk cycles without encoder_change in RUN before fault (1..2^24-1).
REQ-006 SHALL have port clk, input, 1, single system clock; all logic is on its rising edge.
REQ-007 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-008 SHALL have port enable, input, 1, level start/run request.
REQ-009 SHALL have port direction, input, 1, 0 = forward (position increments), 1 = reverse.
REQ-010 SHALL have port encoder_change, input, 1, one-cycle pulse per encoder tick.
REQ-011 SHALL have port loop_gain, input, signed 10, PI controller output.
REQ-012 SHALL have port output_gain, output, signed 10, gain to commutation.
REQ-013 SHALL have port forced_position, output, 11, forced cycle position, 0..1169.
REQ-014 SHALL have port use_forced_position, output, 1, selects forced_position over the encoder-derived position.
REQ-015 SHALL have port loop_enable, output, 1, enables velocity filter and PI controller.
REQ-016 SHALL have port reset_encoder_count, output, 1, one-cycle pulse zeroing the encoder count.
REQ-017 SHALL have port fault, output, 1, stall fault flag.
REQ-018 SHALL have port state, output, 3, current state encoding.

Function
REQ-019 SHALL implement states IDLE=0, ALIGN=1, RAMP=2, RUN=3, FAULT=4; all outputs registered; a transition takes effect on the cycle after its condition is sampled.
REQ-020 IDLE: output_gain 0, forced_position 0, use_forced_position 1, loop_enable 0; enable=1 -> ALIGN, latch direction, load timer with ALIGN_CYCLES-1.
REQ-021 ALIGN: output_gain ALIGN_GAIN, forced_position 0; timer decrements each cycle; at timer 0 -> RAMP, reset_encoder_count=1 for exactly the first RAMP cycle, step counter 0, timer loaded with RAMP_STEP_CYCLES-1.
REQ-022 RAMP: output_gain ALIGN_GAIN; at timer 0, forced_position steps ±1 per latched direction, wrapping 1169->0 forward and 0->1169 reverse, step counter increments and timer reloads; when step counter reaches RAMP_STEPS -> RUN.
REQ-023 RUN: use_forced_position 0, loop_enable 1, output_gain = loop_gain registered (1-cycle latency); stall counter clears on encoder_change, otherwise increments; at STALL_CYCLES-1 without encoder_change -> FAULT.
REQ-024 Simultaneous encoder_change and stall terminal count SHALL clear the counter and not fault.
REQ-025 FAULT: output_gain 0, loop_enable 0, use_forced_position 1, fault 1; fault is sticky until enable sampled 0 -> IDLE, with fault 0 from the IDLE cycle.
REQ-026 enable=0 in ALIGN, RAMP or RUN SHALL force IDLE next cycle, with priority over every other transition.
REQ-027 Changes to direction after leaving IDLE SHALL be ignored until the next IDLE->ALIGN transition.
REQ-028 Timers SHALL be 24-bit and the step counter 16-bit, with no overflow within the parameter ranges.

Reset
REQ-029 reset SHALL force IDLE and set output_gain 0, forced_position 0, use_forced_position 1, loop_enable 0, reset_encoder_count 0, fault 0, and all counters 0, regardless of enable.
REQ-030 reset SHALL take priority over every transition, including reset asserted mid-ALIGN, mid-RAMP or in FAULT.

Structure
REQ-031 A shared package bldc_pkg SHALL hold the state enum typedef and CYCLE_LENGTH=1170, reused by fastModulo1170 users.
REQ-032 The wrapping ±1 position counter SHALL be a sub-module named position_stepper, with inputs step and direction and an 11-bit position output.

Verification (ALIGN_CYCLES=8, RAMP_STEP_CYCLES=4, RAMP_STEPS=3, STALL_CYCLES=10, ALIGN_GAIN=200)
REQ-033 enable=1, direction=0, encoder pulses every 5 cycles -> ALIGN for 8 cycles with gain 200, pos 0; one reset_encoder_count pulse; pos 1,2,3 at 4-cycle spacing; RUN with output_gain = loop_gain one cycle later.
REQ-034 direction=1 start -> forced_position 0 -> 1169 -> 1168 -> 1167, then RUN.
REQ-035 In RUN, no encoder_change for 10 cycles -> FAULT, gain 0, fault 1; hold enable=1 -> stays in FAULT; drop enable -> IDLE, fault 0.
REQ-036 In RUN, encoder_change exactly on the stall terminal cycle -> remains in RUN, no fault.
REQ-037 enable dropped mid-RAMP, and reset pulsed mid-ALIGN -> IDLE next cycle with all outputs at reset values; no reset_encoder_count pulse.

Source files
------------

// File: rtl/bldc_pkg.sv
// rtl/bldc_pkg.sv - shared BLDC state encoding and electrical-cycle length
package bldc_pkg;

  // One electrical cycle of forced/encoder position, shared with fastModulo1170 users
  localparam int unsigned CYCLE_LENGTH = 1170;
  localparam logic [10:0] POS_MAX      = 11'(CYCLE_LENGTH - 1);

  typedef enum logic [2:0] {
    BLDC_IDLE  = 3'd0,
    BLDC_ALIGN = 3'd1,
    BLDC_RAMP  = 3'd2,
    BLDC_RUN   = 3'd3,
    BLDC_FAULT = 3'd4
  } bldc_state_e;

  localparam logic [2:0] ST_IDLE  = BLDC_IDLE;
  localparam logic [2:0] ST_ALIGN = BLDC_ALIGN;
  localparam logic [2:0] ST_RAMP  = BLDC_RAMP;
  localparam logic [2:0] ST_RUN   = BLDC_RUN;
  localparam logic [2:0] ST_FAULT = BLDC_FAULT;

endpackage

// File: rtl/position_stepper.sv
// rtl/position_stepper.sv - wrapping +/-1 forced position counter over one electrical cycle
module position_stepper
  import bldc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        step,
  input  logic        direction,
  output logic [10:0] position
);

  logic [10:0] pos_q, pos_d;

  always_comb begin
    pos_d = pos_q;
    if (clear) begin
      pos_d = '0;
    end else if (step) begin
      if (direction) begin
        pos_d = (pos_q == '0) ? POS_MAX : pos_q - 11'd1;
      end else begin
        pos_d = (pos_q == POS_MAX) ? '0 : pos_q + 11'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pos_q <= '0;
    end else begin
      pos_q <= pos_d;
    end
  end

  assign position = pos_q;

endmodule

// File: rtl/bldc_startup_sequencer.sv
// rtl/bldc_startup_sequencer.sv - BLDC start-up: rotor align, forced ramp, closed-loop run, stall fault
module bldc_startup_sequencer
  import bldc_pkg::*;
#(
  parameter int unsigned       ALIGN_CYCLES     = 1_000_000,
  parameter logic signed [9:0] ALIGN_GAIN       = 10'sd200,
  parameter int unsigned       RAMP_STEP_CYCLES = 5000,
  parameter int unsigned       RAMP_STEPS       = 2340,
  parameter int unsigned       STALL_CYCLES     = 2_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              direction,
  input  logic              encoder_change,
  input  logic signed [9:0] loop_gain,
  output logic signed [9:0] output_gain,
  output logic [10:0]       forced_position,
  output logic              use_forced_position,
  output logic              loop_enable,
  output logic              reset_encoder_count,
  output logic              fault,
  output logic [2:0]        state
);

  localparam logic [23:0] ALIGN_LOAD = 24'(ALIGN_CYCLES - 1);
  localparam logic [23:0] STEP_LOAD  = 24'(RAMP_STEP_CYCLES - 1);
  localparam logic [23:0] STALL_LAST = 24'(STALL_CYCLES - 1);
  localparam logic [15:0] STEPS_DONE = 16'(RAMP_STEPS);

  logic [2:0]        state_q, state_d;
  logic [23:0]       timer_q, timer_d;
  logic [23:0]       stall_q, stall_d;
  logic [15:0]       step_cnt_q, step_cnt_d;
  logic              dir_q, dir_d;
  logic signed [9:0] gain_q, gain_d;
  logic              use_forced_q, use_forced_d;
  logic              loop_en_q, loop_en_d;
  logic              rst_enc_q, rst_enc_d;
  logic              fault_q, fault_d;
  logic              step_pos, clear_pos;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    stall_d    = stall_q;
    step_cnt_d = step_cnt_q;
    dir_d      = dir_q;
    step_pos   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_ALIGN;
          dir_d   = direction;
          timer_d = ALIGN_LOAD;
        end
      end
      ST_ALIGN: begin
        if (timer_q == '0) begin
          state_d    = ST_RAMP;
          timer_d    = STEP_LOAD;
          step_cnt_d = '0;
        end else begin
          timer_d = timer_q - 24'd1;
        end
      end
      ST_RAMP: begin
        if (step_cnt_q == STEPS_DONE) begin
          state_d = ST_RUN;
          stall_d = '0;
        end else if (timer_q == '0) begin
          step_pos   = 1'b1;
          step_cnt_d = step_cnt_q + 16'd1;
          timer_d    = STEP_LOAD;
        end else begin
          timer_d = timer_q - 24'd1;
        end
      end
      ST_RUN: begin
        // An encoder tick on the terminal cycle still counts as motion
        if (encoder_change) begin
          stall_d = '0;
        end else if (stall_q == STALL_LAST) begin
          state_d = ST_FAULT;
        end else begin
          stall_d = stall_q + 24'd1;
        end
      end
      ST_FAULT: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (!enable && (state_q == ST_ALIGN || state_q == ST_RAMP || state_q == ST_RUN)) begin
      state_d  = ST_IDLE;
      step_pos = 1'b0;
    end

    if (state_d == ST_IDLE) begin
      timer_d    = '0;
      stall_d    = '0;
      step_cnt_d = '0;
    end

    // Outputs are registered from the next state so they line up with state
    case (state_d)
      ST_ALIGN, ST_RAMP: gain_d = ALIGN_GAIN;
      ST_RUN:            gain_d = loop_gain;
      default:           gain_d = '0;
    endcase
    use_forced_d = (state_d != ST_RUN);
    loop_en_d    = (state_d == ST_RUN);
    rst_enc_d    = (state_q == ST_ALIGN) && (state_d == ST_RAMP);
    fault_d      = (state_d == ST_FAULT);
    clear_pos    = (state_d == ST_IDLE) || (state_d == ST_ALIGN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      stall_q      <= '0;
      step_cnt_q   <= '0;
      dir_q        <= 1'b0;
      gain_q       <= '0;
      use_forced_q <= 1'b1;
      loop_en_q    <= 1'b0;
      rst_enc_q    <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      stall_q      <= stall_d;
      step_cnt_q   <= step_cnt_d;
      dir_q        <= dir_d;
      gain_q       <= gain_d;
      use_forced_q <= use_forced_d;
      loop_en_q    <= loop_en_d;
      rst_enc_q    <= rst_enc_d;
      fault_q      <= fault_d;
    end
  end

  position_stepper u_stepper (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear_pos),
    .step      (step_pos),
    .direction (dir_q),
    .position  (forced_position)
  );

  assign state               = state_q;
  assign output_gain         = gain_q;
  assign use_forced_position = use_forced_q;
  assign loop_enable         = loop_en_q;
  assign reset_encoder_count = rst_enc_q;
  assign fault               = fault_q;

endmodule
